// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NUM_REQ requesters.
// Each grant runs a fixed IDLE -> EXEC -> RESP transaction with a registered result.
module adder_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_A,
  input  logic [NUM_REQ*WIDTH-1:0]   req_B,
  input  logic [NUM_REQ-1:0]         req_sub,
  output logic [WIDTH-1:0]           add_A,
  output logic [WIDTH-1:0]           add_B,
  output logic                       add_sub,
  input  logic [WIDTH-1:0]           add_out,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [WIDTH-1:0]           result,
  output logic                       overflow,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [IDX_W:0]   NR   = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ-1);

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                rr_ptr, gidx, win;
  logic                            win_vld;
  logic [IDX_W:0]                  cand;
  logic [NUM_REQ-1:0][WIDTH-1:0]   a_arr, b_arr;
  logic                            sa, sb, sr, ovf;

  assign a_arr = req_A;
  assign b_arr = req_B;

  // Scan downward so the candidate nearest rr_ptr is the last (winning) assignment.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= NR) cand = cand - NR;
      if (req[cand[IDX_W-1:0]]) begin
        win     = cand[IDX_W-1:0];
        win_vld = 1'b1;
      end
    end
  end

  assign sa  = add_A[WIDTH-1];
  assign sb  = add_B[WIDTH-1];
  assign sr  = add_out[WIDTH-1];
  assign ovf = add_sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == EXEC) || (state == RESP);
    done = (state == RESP) ? grant : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      gidx     <= '0;
      grant    <= '0;
      add_A    <= '0;
      add_B    <= '0;
      add_sub  <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          add_A   <= a_arr[win];
          add_B   <= b_arr[win];
          add_sub <= req_sub[win];
          grant   <= NUM_REQ'(1) << win;
          gidx    <= win;
        end
        EXEC: begin
          result   <= add_out;
          overflow <= ovf;
        end
        RESP: begin
          grant  <= '0;
          rr_ptr <= (gidx == LAST) ? '0 : gidx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: a behavioural adder closes the datapath loop,
// expected values are hand-computed constants.
module tb_adder_arbiter;
  localparam int WIDTH = 16, NUM_REQ = 3, IDX_W = 2;

  logic                     clk, reset_n;
  logic [NUM_REQ-1:0]       req, req_sub, grant, done;
  logic [NUM_REQ*WIDTH-1:0] req_A, req_B;
  logic [WIDTH-1:0]         add_A, add_B, add_out, result;
  logic                     add_sub, overflow, busy;
  int                       passed = 0, failed = 0, total = 0;
  logic [NUM_REQ-1:0]       eg;

  adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_A(req_A), .req_B(req_B),
    .req_sub(req_sub), .add_A(add_A), .add_B(add_B), .add_sub(add_sub),
    .add_out(add_out), .grant(grant), .done(done), .result(result),
    .overflow(overflow), .busy(busy)
  );

  // The shared adder itself
  assign add_out = add_sub ? add_A - add_B : add_A + add_B;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input logic s);
    req_A[i*WIDTH +: WIDTH] = a;
    req_B[i*WIDTH +: WIDTH] = b;
    req_sub[i] = s;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; req = '0; req_A = '0; req_B = '0; req_sub = '0;
    #3;
    chk("rst_grant",  16'(grant),    16'h0);
    chk("rst_done",   16'(done),     16'h0);
    chk("rst_busy",   16'(busy),     16'h0);
    chk("rst_result", result,        16'h0);
    chk("rst_ovf",    16'(overflow), 16'h0);
    chk("rst_addA",   add_A,         16'h0);
    #4 reset_n = 1'b1;
    tick();

    // single add
    op(0, 16'd100, 16'd250, 1'b0); req = 3'b001;
    tick();
    chk("t1_grant", 16'(grant), 16'h1);
    chk("t1_busy",  16'(busy),  16'h1);
    chk("t1_addA",  add_A,      16'd100);
    chk("t1_addB",  add_B,      16'd250);
    chk("t1_done0", 16'(done),  16'h0);
    op(0, 16'd0, 16'd0, 1'b1);
    tick();
    chk("t1_done",  16'(done),     16'h1);
    chk("t1_res",   result,        16'd350);
    chk("t1_ovf",   16'(overflow), 16'h0);
    req = 3'b000;
    tick();
    chk("t1_idle_done",  16'(done),  16'h0);
    chk("t1_idle_busy",  16'(busy),  16'h0);
    chk("t1_idle_grant", 16'(grant), 16'h0);
    chk("t1_hold_res",   result,     16'd350);

    // signed overflow, sub then add
    op(1, 16'h8000, 16'd1, 1'b1); req = 3'b010;
    tick();
    chk("t2_grant", 16'(grant), 16'h2);
    tick();
    chk("t2_done",  16'(done),     16'h2);
    chk("t2_res",   result,        16'h7FFF);
    chk("t2_ovf",   16'(overflow), 16'h1);
    req = 3'b000;
    tick();
    op(1, 16'd30000, 16'd10000, 1'b0); req = 3'b010;
    tick();
    chk("t3_grant", 16'(grant), 16'h2);
    tick();
    chk("t3_done",  16'(done),     16'h2);
    chk("t3_res",   result,        16'h9C40);
    chk("t3_ovf",   16'(overflow), 16'h1);
    req = 3'b000;
    tick();

    // contention from reset
    reset_n = 1'b0;
    op(0, 16'd1, 16'd1, 1'b0); op(1, 16'd2, 16'd2, 1'b0); op(2, 16'd3, 16'd3, 1'b0);
    req = 3'b111;
    #2 reset_n = 1'b1;
    tick();
    chk("c_grant0", 16'(grant), 16'h1);
    tick();
    chk("c_done0", 16'(done), 16'h1);
    chk("c_res0",  result,    16'd2);
    req = 3'b110;
    tick();
    chk("c_gap0", 16'(done), 16'h0);
    tick();
    chk("c_grant1", 16'(grant), 16'h2);
    tick();
    chk("c_done1", 16'(done), 16'h2);
    chk("c_res1",  result,    16'd4);
    req = 3'b100;
    tick();
    chk("c_gap1", 16'(done), 16'h0);
    tick();
    chk("c_grant2", 16'(grant), 16'h4);
    tick();
    chk("c_done2", 16'(done), 16'h4);
    chk("c_res2",  result,    16'd6);
    req = 3'b000;
    tick();
    chk("c_idle_busy", 16'(busy), 16'h0);

    // fairness: req1 held, req0 re-asserts after each done
    req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 0) ? 3'b001 : 3'b010;
      tick();
      chk("f_grant", 16'(grant), 16'(eg));
      tick();
      chk("f_done", 16'(done), 16'(eg));
      if (done[0]) req[0] = 1'b0;
      tick();
      req[0] = 1'b1;
    end
    req = 3'b000;
    tick();

    // abandoned request still completes
    op(2, 16'd1, 16'd2, 1'b1); req = 3'b100;
    tick();
    chk("a_grant", 16'(grant), 16'h4);
    req = 3'b000;
    tick();
    chk("a_done", 16'(done),     16'h4);
    chk("a_res",  result,        16'hFFFF);
    chk("a_ovf",  16'(overflow), 16'h0);
    tick();
    chk("a_busy",  16'(busy),  16'h0);
    chk("a_grant_clr", 16'(grant), 16'h0);
    chk("a_done_clr",  16'(done),  16'h0);

    // asynchronous reset mid-EXEC
    op(0, 16'd7, 16'd1, 1'b0); req = 3'b001;
    tick();
    chk("r_grant", 16'(grant), 16'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("r_grant0", 16'(grant),    16'h0);
    chk("r_done0",  16'(done),     16'h0);
    chk("r_busy0",  16'(busy),     16'h0);
    chk("r_res0",   result,        16'h0);
    chk("r_addA0",  add_A,         16'h0);
    chk("r_addB0",  add_B,         16'h0);
    chk("r_sub0",   16'(add_sub),  16'h0);
    op(0, 16'd5, 16'd3, 1'b1);
    #1 reset_n = 1'b1;
    tick();
    chk("r2_grant", 16'(grant), 16'h1);
    chk("r2_done0", 16'(done),  16'h0);
    tick();
    chk("r2_done", 16'(done),     16'h1);
    chk("r2_res",  result,        16'd2);
    chk("r2_ovf",  16'(overflow), 16'h0);
    req = 3'b000;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
